// File: rtl/bru_pkg.sv
// Shared definitions for the branch unit: one-hot decode bit positions, FSM state type,
// default datapath width and the control-bit priority helper.
package bru_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam int IDX_BEQ  = 0;
    localparam int IDX_BNE  = 1;
    localparam int IDX_BLT  = 2;
    localparam int IDX_BGE  = 3;
    localparam int IDX_BLTU = 4;
    localparam int IDX_BGEU = 5;
    localparam int IDX_JAL  = 6;
    localparam int IDX_JALR = 7;

    localparam int NUM_BR   = IDX_BGEU + 1;
    localparam int NUM_CTRL = IDX_JALR + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        DONE     = 2'd2
    } state_t;

    // Keep only the lowest-index set bit so a malformed decode resolves deterministically.
    function automatic logic [NUM_CTRL-1:0] lowest_ctrl(input logic [NUM_CTRL-1:0] c);
        return c & (-c);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluation: equality, signed and unsigned ordering selected by a
// one-hot branch opcode. Purely combinational.
module branch_cmp
    import bru_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [NUM_BR-1:0] op,
    output logic              cond
);

    logic signed [XLEN-1:0] s1;
    logic signed [XLEN-1:0] s2;
    logic                   eq;
    logic                   lt_s;
    logic                   lt_u;

    assign s1   = rs1;
    assign s2   = rs2;
    assign eq   = (rs1 == rs2);
    assign lt_s = (s1 < s2);
    assign lt_u = (rs1 < rs2);

    always_comb begin
        cond = 1'b0;
        if (op[IDX_BEQ])  cond = eq;
        if (op[IDX_BNE])  cond = !eq;
        if (op[IDX_BLT])  cond = lt_s;
        if (op[IDX_BGE])  cond = !lt_s;
        if (op[IDX_BLTU]) cond = lt_u;
        if (op[IDX_BGEU]) cond = !lt_u;
    end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution unit: accepts one decoded instruction, waits for its operands,
// and presents next_pc/taken/link_value until consumed. Optional target-alignment trap
// enabled by defining BRU_MISALIGN_TRAP_EN.
module branch_unit
    import bru_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int IBUS_W = 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [IBUS_W-1:0] instr_bus,
    output logic              rs1_read,
    output logic              rs2_read,
    input  logic              rs1_valid,
    input  logic              rs2_valid,
    input  logic [XLEN-1:0]   rs1_value,
    input  logic [XLEN-1:0]   rs2_value,
    output logic              pc_j_valid,
    input  logic              res_ready,
    output logic [XLEN-1:0]   next_pc,
    output logic              taken,
    output logic [XLEN-1:0]   link_value,
`ifdef BRU_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    input  logic              flush
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_t                state_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       imm_q;
    logic [NUM_CTRL-1:0]   op_q;
    logic                  rs1_read_q;
    logic                  rs2_read_q;
    logic                  pc_j_valid_q;
    logic                  taken_q;
    logic [XLEN-1:0]       next_pc_q;
    logic [XLEN-1:0]       link_q;
`ifdef BRU_MISALIGN_TRAP_EN
    logic                  misalign_q;
    logic                  misalign_d;
`endif

    logic [NUM_CTRL-1:0]   op_in;
    logic                  is_br;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  ops_ok;
    logic                  cond;
    logic [XLEN-1:0]       pc4;
    logic [XLEN-1:0]       raw_target;
    logic [XLEN-1:0]       target;
    logic                  taken_d;
    logic [XLEN-1:0]       next_pc_d;
    logic                  unused_bus;

    assign op_in      = lowest_ctrl(instr_bus[NUM_CTRL-1:0]);
    assign unused_bus = ^instr_bus[IBUS_W-1:NUM_CTRL];

    assign is_br   = |op_q[IDX_BGEU:IDX_BEQ];
    assign is_jal  = op_q[IDX_JAL];
    assign is_jalr = op_q[IDX_JALR];
    assign ops_ok  = (!(is_br || is_jalr) || rs1_valid) && (!is_br || rs2_valid);

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1  (rs1_value),
        .rs2  (rs2_value),
        .op   (op_q[IDX_BGEU:IDX_BEQ]),
        .cond (cond)
    );

    always_comb begin
        pc4        = pc_q + FOUR;
        raw_target = (is_jalr ? rs1_value : pc_q) + imm_q;
        target     = is_jalr ? {raw_target[XLEN-1:1], 1'b0} : raw_target;
        taken_d    = is_jal || is_jalr || (is_br && cond);
`ifdef BRU_MISALIGN_TRAP_EN
        // A misaligned target traps instead of redirecting: fall through to pc+4.
        misalign_d = taken_d && target[1];
        if (misalign_d) taken_d = 1'b0;
`endif
        next_pc_d  = taken_d ? target : pc4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rs1_read_q   <= 1'b0;
            rs2_read_q   <= 1'b0;
            pc_j_valid_q <= 1'b0;
            taken_q      <= 1'b0;
            next_pc_q    <= '0;
            link_q       <= '0;
`ifdef BRU_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else if (flush) begin
            state_q      <= IDLE;
            rs1_read_q   <= 1'b0;
            rs2_read_q   <= 1'b0;
            pc_j_valid_q <= 1'b0;
`ifdef BRU_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        pc_q       <= pc;
                        imm_q      <= imm;
                        op_q       <= op_in;
                        rs1_read_q <= |op_in[IDX_BGEU:IDX_BEQ] || op_in[IDX_JALR];
                        rs2_read_q <= |op_in[IDX_BGEU:IDX_BEQ];
                        state_q    <= WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (ops_ok) begin
                        rs1_read_q   <= 1'b0;
                        rs2_read_q   <= 1'b0;
                        pc_j_valid_q <= 1'b1;
                        taken_q      <= taken_d;
                        next_pc_q    <= next_pc_d;
                        link_q       <= pc4;
`ifdef BRU_MISALIGN_TRAP_EN
                        misalign_q   <= misalign_d;
`endif
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        pc_j_valid_q <= 1'b0;
`ifdef BRU_MISALIGN_TRAP_EN
                        misalign_q   <= 1'b0;
`endif
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rs1_read   = rs1_read_q;
    assign rs2_read   = rs2_read_q;
    assign pc_j_valid = pc_j_valid_q;
    assign taken      = taken_q;
    assign next_pc    = next_pc_q;
    assign link_value = link_q;
`ifdef BRU_MISALIGN_TRAP_EN
    assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit with hand-computed expectations.
module tb_branch_unit;

    localparam int BEQ = 0, BNE = 1, BLT = 2, BGE = 3, BLTU = 4, BGEU = 5, JAL = 6, JALR = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [36:0] instr_bus;
    logic        rs1_read, rs2_read;
    logic        rs1_valid, rs2_valid;
    logic [31:0] rs1_value, rs2_value;
    logic        pc_j_valid;
    logic        res_ready;
    logic [31:0] next_pc;
    logic        taken;
    logic [31:0] link_value;
    logic        flush;
`ifdef BRU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .pc         (pc),
        .imm        (imm),
        .instr_bus  (instr_bus),
        .rs1_read   (rs1_read),
        .rs2_read   (rs2_read),
        .rs1_valid  (rs1_valid),
        .rs2_valid  (rs2_valid),
        .rs1_value  (rs1_value),
        .rs2_value  (rs2_value),
        .pc_j_valid (pc_j_valid),
        .res_ready  (res_ready),
        .next_pc    (next_pc),
        .taken      (taken),
        .link_value (link_value),
`ifdef BRU_MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] bus_of(input int a, input int b);
        logic [36:0] v;
        v = '0;
        v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    // Offer one instruction for exactly one cycle; afterwards the unit is in WAIT_OPS.
    task automatic issue(input logic [36:0] bus, input logic [31:0] p, input logic [31:0] i);
        instr_bus = bus;
        pc        = p;
        imm       = i;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        instr_bus = '0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic va, input logic vb);
        rs1_value = a;
        rs2_value = b;
        rs1_valid = va;
        rs2_valid = vb;
    endtask

    task automatic run_branch(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] p, input logic [31:0] i,
                              input logic exp_taken, input logic [31:0] exp_pc);
        set_ops(a, b, 1'b1, 1'b1);
        issue(bus_of(op, -1), p, i);
        tick();
        check({tag, "_valid"}, pc_j_valid, 1);
        check({tag, "_taken"}, taken, exp_taken);
        check({tag, "_next_pc"}, next_pc, exp_pc);
        consume();
    endtask

    initial begin
        rst = 1'b1; req_valid = 0; pc = 0; imm = 0; instr_bus = '0;
        res_ready = 0; flush = 0;
        set_ops(0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;

        check("rst_req_ready", req_ready, 1);
        check("rst_pc_j_valid", pc_j_valid, 0);
        check("rst_taken", taken, 0);
        check("rst_next_pc", next_pc, 0);
        check("rst_link", link_value, 0);
        check("rst_rs1_read", rs1_read, 0);
        check("rst_rs2_read", rs2_read, 0);

        // BEQ taken, latency 2 from accept cycle
        set_ops(5, 5, 1, 1);
        issue(bus_of(BEQ, -1), 32'h100, 32'd8);
        check("beq_wait_ready", req_ready, 0);
        check("beq_wait_valid", pc_j_valid, 0);
        check("beq_rs1_read", rs1_read, 1);
        check("beq_rs2_read", rs2_read, 1);
        tick();
        check("beq_valid", pc_j_valid, 1);
        check("beq_taken", taken, 1);
        check("beq_next_pc", next_pc, 32'h108);
        check("beq_link", link_value, 32'h104);
        check("beq_reads_clr", rs1_read, 0);
        consume();
        check("beq_idle_valid", pc_j_valid, 0);
        check("beq_idle_ready", req_ready, 1);

        run_branch("blt",  BLT,  32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 32'h210);
        run_branch("bltu", BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 0, 32'h204);
        run_branch("bge",  BGE,  32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 0, 32'h204);
        run_branch("bgeu", BGEU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 32'h210);
        run_branch("bne_eq", BNE, 32'd7, 32'd7, 32'h240, 32'h40, 0, 32'h244);
        // Two control bits set: BEQ (lower) wins over BLTU
        set_ops(3, 3, 1, 1);
        issue(bus_of(BEQ, BLTU), 32'h500, 32'h20);
        tick();
        check("multi_taken", taken, 1);
        check("multi_next_pc", next_pc, 32'h520);
        consume();

        // JALR with rs2 never valid
        set_ops(32'h203, 0, 1, 0);
        issue(bus_of(JALR, -1), 32'h300, 32'd4);
        check("jalr_rs1_read", rs1_read, 1);
        check("jalr_rs2_read", rs2_read, 0);
        tick();
        check("jalr_valid", pc_j_valid, 1);
        check("jalr_taken", taken, 1);
        check("jalr_next_pc", next_pc, 32'h206);
        check("jalr_link", link_value, 32'h304);
        consume();

        // BNE waiting on a late rs2, then outputs held while res_ready is low
        set_ops(1, 2, 1, 0);
        issue(bus_of(BNE, -1), 32'h400, 32'hFFFF_FFE0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bne_wait_ready", req_ready, 0);
            check("bne_wait_valid", pc_j_valid, 0);
        end
        rs2_valid = 1'b1;
        tick();
        check("bne_valid", pc_j_valid, 1);
        check("bne_taken", taken, 1);
        check("bne_next_pc", next_pc, 32'h3E0);
        set_ops(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_valid", pc_j_valid, 1);
            check("hold_next_pc", next_pc, 32'h3E0);
            check("hold_taken", taken, 1);
        end
        flush = 1'b1; res_ready = 1'b1;
        tick();
        flush = 1'b0; res_ready = 1'b0;
        check("flush_done_valid", pc_j_valid, 0);
        check("flush_done_ready", req_ready, 1);

        // Flush beats a simultaneous request in IDLE
        flush = 1'b1;
        issue(bus_of(BEQ, -1), 32'h600, 32'd8);
        flush = 1'b0;
        check("flush_req_ready", req_ready, 1);
        check("flush_req_rs1", rs1_read, 0);

        // Flush while waiting on operands
        set_ops(0, 0, 0, 0);
        issue(bus_of(BEQ, -1), 32'h600, 32'd8);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wait_ready", req_ready, 1);
        check("flush_wait_rs1", rs1_read, 0);
        check("flush_wait_rs2", rs2_read, 0);

        // Non-control instruction exits WAIT_OPS immediately without operands
        issue(bus_of(20, -1), 32'h700, 32'h80);
        check("nop_rs1_read", rs1_read, 0);
        tick();
        check("nop_valid", pc_j_valid, 1);
        check("nop_taken", taken, 0);
        check("nop_next_pc", next_pc, 32'h704);
        consume();

        // JAL wrapping past 2^32
        issue(bus_of(JAL, -1), 32'hFFFF_FFFC, 32'd8);
        tick();
        check("jal_taken", taken, 1);
        check("jal_next_pc", next_pc, 32'h4);
        check("jal_link", link_value, 32'h0);
        consume();

`ifdef BRU_MISALIGN_TRAP_EN
        issue(bus_of(JAL, -1), 32'hFFFF_FFFC, 32'd6);
        tick();
        check("mis_flag", misalign, 1);
        check("mis_taken", taken, 0);
        check("mis_next_pc", next_pc, 32'h0);
        consume();
`endif

        // Reset mid-operation discards the instruction, with priority over flush
        set_ops(0, 0, 0, 0);
        issue(bus_of(BEQ, -1), 32'h800, 32'd8);
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_valid", pc_j_valid, 0);
        check("rst_mid_next_pc", next_pc, 0);
        check("rst_mid_link", link_value, 0);
        check("rst_mid_rs1", rs1_read, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-002 SHALL have parameter IBUS_W, default 37, meaning decoded one-hot instruction bus width.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: req_valid  in  1  instruction offered; req_ready  out  1  unit can accept.
REQ-005 SHALL have ports: pc  in  XLEN  instruction PC; imm  in  XLEN  signed immediate; instr_bus  in  IBUS_W  one-hot decode.
REQ-006 SHALL have ports: rs1_read, rs2_read  out  1 each  operand request; rs1_valid, rs2_valid  in  1 each  operand present.
REQ-007 SHALL have ports: rs1_value, rs2_value  in  XLEN each  signed operands.
REQ-008 SHALL have ports: pc_j_valid  out  1  result valid; res_ready  in  1  consumer accepts.
REQ-009 SHALL have ports: next_pc  out  XLEN; taken  out  1; link_value  out  XLEN (pc+4).
REQ-010 SHALL have port flush  in  1  abort current operation.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_OPS, DONE; req_ready=1 only in IDLE.
REQ-012 SHALL, in IDLE with req_valid, latch pc/imm/instr_bus and go to WAIT_OPS.
REQ-013 SHALL assert rs1_read in WAIT_OPS for BEQ/BNE/BLT/BGE/BLTU/BGEU/JALR, and rs2_read for the six branches only.
REQ-014 SHALL stay in WAIT_OPS until every requested operand's valid is high in the same cycle, then sample operands, register results and go to DONE.
REQ-015 SHALL, for non-control instructions (no control bit set), skip operand wait: WAIT_OPS exits on its first cycle with taken=0.
REQ-016 SHALL compute: branch target pc+imm; JAL target pc+imm, taken=1; JALR target (rs1+imm) with bit0 cleared, taken=1.
REQ-017 SHALL compare BLT/BGE signed and BLTU/BGEU unsigned.
REQ-018 SHALL drive next_pc = taken ? target : pc+4; all adds modulo 2^XLEN (wrap, no overflow flag).
REQ-019 SHALL hold pc_j_valid=1 with stable outputs in DONE until res_ready=1, then return to IDLE.
REQ-020 SHALL give latency of 2 cycles from accept to pc_j_valid when operands are already valid.
REQ-021 SHALL, on flush in any state, go to IDLE next cycle with pc_j_valid=0; flush wins over simultaneous req_valid or res_ready.
REQ-022 SHALL treat instr_bus with more than one control bit set as the lowest-index set control bit.

Reset
REQ-023 SHALL, on rst, enter IDLE and clear pc_j_valid, taken, next_pc, link_value, rs1_read, rs2_read to 0.
REQ-024 SHALL, with rst mid-operation, discard latched instruction; rst has priority over flush.

Configuration
REQ-025 SHALL, with BRU_MISALIGN_TRAP_EN defined, add output misalign (1 bit): set in DONE when taken and target[1]=1; next_pc then = pc+4, taken=0.
REQ-026 SHALL, without BRU_MISALIGN_TRAP_EN, omit misalign and use target unchanged.

Structure
REQ-027 SHALL take from shared package bru_pkg: one-hot bit index constants (IDX_BEQ..IDX_BGEU, IDX_JAL, IDX_JALR), state typedef, default XLEN.
REQ-028 SHALL place comparison in one combinational sub-module branch_cmp (rs1, rs2, one-hot op -> cond).

Verification
REQ-029 BEQ, pc=0x100, imm=8, rs1=rs2=5 valid at accept -> pc_j_valid 2 cycles later, taken=1, next_pc=0x108.
REQ-030 BLT rs1=-1, rs2=1 -> taken=1; BLTU same values -> taken=0, next_pc=pc+4.
REQ-031 JALR rs1=0x203, imm=4, rs2_valid held 0 -> only rs1_read asserted, next_pc=0x206, link_value=pc+4.
REQ-032 BNE with rs2_valid delayed 5 cycles -> stays in WAIT_OPS, req_ready=0, result 1 cycle after rs2_valid.
REQ-033 res_ready low 3 cycles in DONE -> outputs stable; flush asserted with res_ready -> IDLE, pc_j_valid=0.
REQ-034 JAL pc=0xFFFFFFFC, imm=8 -> next_pc=0x4 (wrap); with BRU_MISALIGN_TRAP_EN, imm=6 -> misalign=1, taken=0.
